// File: rtl/pixel_write_combiner.sv
// Pixel write combiner: folds 4-bit pixel writes into masked 16-bit word writes
// and queues them for the frame buffer write port under a ready handshake.
module pwc_nibble_lane (
    input  logic       fresh_i,
    input  logic       hit_i,
    input  logic [3:0] pix_i,
    input  logic [3:0] cur_data_i,
    input  logic       cur_mask_i,
    output logic [3:0] nxt_data_o,
    output logic       nxt_mask_o
);
    // A fresh word starts from zero so unwritten nibbles go out as 0.
    assign nxt_data_o = hit_i ? pix_i : (fresh_i ? 4'h0 : cur_data_i);
    assign nxt_mask_o = hit_i | (~fresh_i & cur_mask_i);
endmodule

module pixel_write_combiner #(
    parameter int FIFO_DEPTH        = 4,
    parameter int IDLE_FLUSH_CYCLES = 16,
    parameter int PIXEL_LIMIT       = 256000
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        pixel_write_enable_in,
    input  logic [17:0] pixel_write_address_in,
    input  logic [3:0]  pixel_write_data_in,
    input  logic        flush_in,
    input  logic        clear_status_in,
    input  logic        mem_ready_in,
    output logic        mem_write_enable_out,
    output logic [15:0] mem_address_out,
    output logic [15:0] mem_data_out,
    output logic [3:0]  mem_nibble_mask_out,
    output logic        busy_out,
    output logic        overflow_out
);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam int            IW       = $clog2(IDLE_FLUSH_CYCLES + 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FLUSH_CYCLES);
    localparam logic [17:0]   LIMIT_C  = 18'(PIXEL_LIMIT);

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } word_t;

    logic            en_q;
    logic [17:0]     last_addr_q;
    word_t           acc_q, acc_d;
    logic            acc_v_q, acc_v_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            ovf_q, ovf_d;
    word_t           fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [PW:0]     cnt_q;

    logic            cap, cap_ok, same_word, push, fresh;
    logic            full, empty, pop, wr_en, drop;
    logic [15:0]     cap_word;
    logic [1:0]      cap_lane;
    logic [3:0][3:0] lane_data_d;
    logic [3:0]      lane_mask_d;
    word_t           head;

    // A held enable with an unchanged address is one pixel, not many.
    assign cap       = pixel_write_enable_in & (~en_q | (pixel_write_address_in != last_addr_q));
    assign cap_ok    = cap & (pixel_write_address_in < LIMIT_C);
    assign cap_word  = pixel_write_address_in[17:2];
    assign cap_lane  = pixel_write_address_in[1:0];
    assign same_word = acc_q.addr == cap_word;

    assign push  = acc_v_q & ((&acc_q.mask) | flush_in | (idle_q == IDLE_MAX) | (cap_ok & ~same_word));
    assign fresh = push | ~acc_v_q;

    for (genvar n = 0; n < 4; n++) begin : g_lane
        pwc_nibble_lane u_lane (
            .fresh_i    (fresh),
            .hit_i      (cap_ok && (cap_lane == 2'(n))),
            .pix_i      (pixel_write_data_in),
            .cur_data_i (acc_q.data[4*n +: 4]),
            .cur_mask_i (acc_q.mask[n]),
            .nxt_data_o (lane_data_d[n]),
            .nxt_mask_o (lane_mask_d[n])
        );
    end

    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign pop   = ~empty & mem_ready_in;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        acc_d      = acc_q;
        acc_d.addr = cap_ok ? cap_word : acc_q.addr;
        acc_d.data = lane_data_d;
        acc_d.mask = lane_mask_d;
        acc_v_d    = cap_ok | (acc_v_q & ~push);
        idle_d     = idle_q;
        if (cap || !acc_v_q || push)
            idle_d = '0;
        else if (idle_q != IDLE_MAX)
            idle_d = idle_q + IW'(1);
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop | (ovf_q & ~clear_status_in);
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            en_q        <= 1'b0;
            last_addr_q <= '0;
            acc_q       <= '0;
            acc_v_q     <= 1'b0;
            idle_q      <= '0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            en_q    <= pixel_write_enable_in;
            acc_q   <= acc_d;
            acc_v_q <= acc_v_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            if (cap)
                last_addr_q <= pixel_write_address_in;
            if (wr_en)
                wr_q <= wr_q + PW'(1);
            if (pop)
                rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW + 1)'(wr_en) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clock_in) begin
        if (wr_en)
            fifo_q[wr_q] <= acc_q;
    end

    assign head                 = fifo_q[rd_q];
    assign mem_write_enable_out = ~empty;
    assign mem_address_out      = empty ? '0 : head.addr;
    assign mem_data_out         = empty ? '0 : head.data;
    assign mem_nibble_mask_out  = empty ? '0 : head.mask;
    assign busy_out             = acc_v_q | ~empty;
    assign overflow_out         = ovf_q;
endmodule

// File: tb/tb_pixel_write_combiner.sv
// Bench for pixel_write_combiner: table vectors, directed multi-cycle sequences
// and a randomized run against a word-level reference model.
module tb_pixel_write_combiner;
    localparam int DEPTH = 4;
    localparam int IDLE  = 16;
    localparam int LIMIT = 256000;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, clr, ready;
    logic [17:0] addr;
    logic [3:0]  data;
    logic        we, busy, ovf;
    logic [15:0] maddr, mdata;
    logic [3:0]  mmask;

    always #5 clk = ~clk;

    pixel_write_combiner #(.FIFO_DEPTH(DEPTH), .IDLE_FLUSH_CYCLES(IDLE), .PIXEL_LIMIT(LIMIT)) dut (
        .clock_in(clk), .reset_n_in(rst_n), .pixel_write_enable_in(en),
        .pixel_write_address_in(addr), .pixel_write_data_in(data), .flush_in(flush),
        .clear_status_in(clr), .mem_ready_in(ready), .mem_write_enable_out(we),
        .mem_address_out(maddr), .mem_data_out(mdata), .mem_nibble_mask_out(mmask),
        .busy_out(busy), .overflow_out(ovf)
    );

    typedef logic [35:0] wr_t;
    wr_t  got_q[$], exp_q[$];
    int   got_cyc[$];
    int   n_vec = 0, n_bad = 0, cyc = 0;
    bit   busy_seen = 0, prev_stall = 0;
    logic [36:0] prev_snap;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: per-word nibble list, idle measured from the last capture time.
    int m_nib[4];
    bit m_has[4];
    bit m_valid, m_en_prev;
    int m_word, m_last_cap, m_last_addr;

    function automatic wr_t m_pack();
        int d = 0, m = 0;
        for (int n = 0; n < 4; n++)
            if (m_has[n]) begin
                d += m_nib[n] << (4 * n);
                m += 1 << n;
            end
        return {m_word[15:0], d[15:0], m[3:0]};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_en_prev = 0; m_last_cap = 0; m_last_addr = 0;
        for (int n = 0; n < 4; n++) m_has[n] = 0;
    endtask

    task automatic model_step();
        bit c, ok, all4, p;
        int a, w, ln;
        a    = int'(addr);
        c    = (en === 1'b1) && (!m_en_prev || a != m_last_addr);
        ok   = c && a < LIMIT;
        w    = a / 4;
        ln   = a % 4;
        all4 = m_has[0] && m_has[1] && m_has[2] && m_has[3];
        p    = m_valid && (all4 || flush === 1'b1 || (cyc - m_last_cap - 1 >= IDLE) || (ok && w != m_word));
        if (p) begin
            exp_q.push_back(m_pack());
            m_valid = 0;
            for (int n = 0; n < 4; n++) m_has[n] = 0;
        end
        if (ok) begin
            if (!m_valid) begin
                m_word = w; m_valid = 1;
                for (int n = 0; n < 4; n++) m_has[n] = 0;
            end
            m_nib[ln] = int'(data);
            m_has[ln] = 1;
        end
        if (c) begin
            m_last_cap  = cyc;
            m_last_addr = a;
        end
        m_en_prev = (en === 1'b1);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n !== 1'b1) begin
            model_clear();
            prev_stall = 0;
        end else begin
            model_step();
            if (prev_stall) chk("stall_hold", {we, maddr, mdata, mmask}, prev_snap);
            if (we && ready) begin
                got_q.push_back({maddr, mdata, mmask});
                got_cyc.push_back(cyc);
            end
            if (busy) busy_seen = 1;
            prev_stall = we && !ready;
            prev_snap  = {we, maddr, mdata, mmask};
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic rcycle();
        ready = (ready == 1'b0) ? 1'b1 : ($urandom % 4 != 0);
        cyc1();
    endtask

    task automatic feed_word(int w, int seed);
        for (int n = 0; n < 4; n++) begin
            en = 1; addr = 18'(w * 4 + n); data = 4'((seed + n + 1) & 15);
            cyc1();
        end
    endtask

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][17:0] a;
        logic [3:0][3:0]  d;
        logic             fl;
        logic             none;
        logic [35:0]      exp;
    } vec_t;
    vec_t vt[9];

    function automatic vec_t mk(int n, int a0, int a1, int a2, int a3, int d0, int d1, int d2, int d3,
                                bit fl, bit none, int ea, int ed, int em);
        vec_t v;
        v.n = 3'(n);
        v.a[0] = 18'(a0); v.a[1] = 18'(a1); v.a[2] = 18'(a2); v.a[3] = 18'(a3);
        v.d[0] = 4'(d0);  v.d[1] = 4'(d1);  v.d[2] = 4'(d2);  v.d[3] = 4'(d3);
        v.fl = fl; v.none = none;
        v.exp = {16'(ea), 16'(ed), 4'(em)};
        return v;
    endfunction

    initial begin
        int base;
        wr_t ew;
        vt[0] = mk(4, 0, 1, 2, 3, 1, 2, 3, 4, 0, 0, 0, 16'h4321, 4'hF);
        vt[1] = mk(1, 645, 0, 0, 0, 7, 0, 0, 0, 0, 0, 161, 16'h0070, 4'b0010);
        vt[2] = mk(3, 41, 40, 41, 0, 3, 9, 5, 0, 1, 0, 10, 16'h0059, 4'b0011);
        vt[3] = mk(2, 6, 6, 0, 0, 10, 11, 0, 0, 1, 0, 1, 16'h0A00, 4'b0100);
        vt[4] = mk(1, 255999, 0, 0, 0, 12, 0, 0, 0, 1, 0, 63999, 16'hC000, 4'b1000);
        vt[5] = mk(1, 256000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        vt[6] = mk(1, 262143, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 0, 0);
        vt[7] = mk(2, 1023, 1022, 0, 0, 15, 0, 0, 0, 1, 0, 255, 16'hF000, 4'b1100);
        vt[8] = mk(4, 7, 5, 6, 4, 8, 9, 10, 11, 0, 0, 1, 16'h8A9B, 4'hF);

        rst_n = 0; en = 0; flush = 0; clr = 0; ready = 1; addr = '0; data = '0;
        repeat (3) cyc1();
        chk("rst we", we, 0);     chk("rst addr", maddr, 0); chk("rst data", mdata, 0);
        chk("rst mask", mmask, 0); chk("rst busy", busy, 0); chk("rst ovf", ovf, 0);
        rst_n = 1;
        cyc1();

        for (int i = 0; i < 9; i++) begin
            got_q.delete(); busy_seen = 0;
            for (int k = 0; k < int'(vt[i].n); k++) begin
                en = 1; addr = vt[i].a[k]; data = vt[i].d[k];
                cyc1(); cyc1();
            end
            en = 0;
            if (vt[i].fl) begin flush = 1; cyc1(); flush = 0; end
            repeat (30) cyc1();
            if (vt[i].none) begin
                chk($sformatf("vec%0d writes", i), got_q.size(), 0);
                chk($sformatf("vec%0d busy_seen", i), busy_seen, 0);
            end else begin
                chk($sformatf("vec%0d writes", i), got_q.size(), 1);
                if (got_q.size() > 0) chk($sformatf("vec%0d word", i), got_q[0], vt[i].exp);
                chk($sformatf("vec%0d busy_end", i), busy, 0);
            end
        end

        // Minimum latency: capture in N, flush in N+1, write request in N+2.
        got_q.delete();
        en = 1; addr = 18'd400; data = 4'd3;
        cyc1();
        en = 0; flush = 1;
        chk("lat N+1 we", we, 0);
        cyc1();
        flush = 0;
        chk("lat N+2 we", we, 1);
        chk("lat N+2 word", {maddr, mdata, mmask}, {16'd100, 16'h0003, 4'b0001});
        repeat (5) cyc1();

        // Flush alongside a capture: old word pushed, new pixel starts fresh.
        got_q.delete();
        en = 1; addr = 18'd8; data = 4'd5; cyc1(); cyc1();
        addr = 18'd12; data = 4'd6; flush = 1; cyc1();
        flush = 0; cyc1(); en = 0;
        repeat (30) cyc1();
        chk("flush_diff count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("flush_diff w0", got_q[0], {16'd2, 16'h0005, 4'b0001});
            chk("flush_diff w1", got_q[1], {16'd3, 16'h0006, 4'b0001});
        end
        got_q.delete();
        en = 1; addr = 18'd20; data = 4'd1; cyc1(); cyc1();
        addr = 18'd21; data = 4'd2; flush = 1; cyc1();
        flush = 0; cyc1(); en = 0;
        repeat (30) cyc1();
        chk("flush_same count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("flush_same w0", got_q[0], {16'd5, 16'h0001, 4'b0001});
            chk("flush_same w1", got_q[1], {16'd5, 16'h0020, 4'b0010});
        end

        // Stall with six full words: four kept in order, two dropped.
        ready = 0; got_q.delete(); got_cyc.delete();
        for (int j = 0; j < 6; j++) feed_word(200 + j, 4 * j);
        en = 0;
        repeat (4) cyc1();
        chk("ovf set", ovf, 1);
        chk("ovf head", {we, maddr, mdata, mmask}, {1'b1, 16'd200, 16'h4321, 4'hF});
        repeat (3) cyc1();
        chk("ovf head held", maddr, 200);
        ready = 1;
        repeat (8) cyc1();
        chk("ovf count", got_q.size(), 4);
        for (int j = 0; j < 4 && j < got_q.size(); j++) begin
            for (int n = 0; n < 4; n++) ew[4 + 4 * n +: 4] = 4'((4 * j + n + 1) & 15);
            ew[35:20] = 16'(200 + j);
            ew[3:0]   = 4'hF;
            chk($sformatf("ovf w%0d", j), got_q[j], ew);
            chk($sformatf("ovf tput%0d", j), got_cyc[j] - got_cyc[0], j);
        end
        chk("ovf sticky", ovf, 1);
        clr = 1; cyc1(); clr = 0;
        chk("ovf cleared", ovf, 0);

        // Reset mid-operation discards queue and accumulator.
        ready = 0;
        for (int j = 0; j < 3; j++) feed_word(300 + j, j);
        en = 1; addr = 18'(303 * 4); data = 4'd1; cyc1();
        en = 0;
        repeat (3) cyc1();
        chk("pre-rst we", we, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst we", we, 0);     chk("midrst addr", maddr, 0); chk("midrst data", mdata, 0);
        chk("midrst mask", mmask, 0); chk("midrst busy", busy, 0); chk("midrst ovf", ovf, 0);
        cyc1();
        rst_n = 1; ready = 1; got_q.delete();
        repeat (30) cyc1();
        chk("postrst writes", got_q.size(), 0);
        chk("postrst busy", busy, 0);

        // Randomized run against the reference model.
        rst_n = 0; cyc1(); rst_n = 1;
        exp_q.delete(); got_q.delete();
        base = 0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom % 4 == 0) begin
                en = 0;
                repeat ($urandom_range(1, 22)) rcycle();
            end
            if ($urandom % 4 == 0) base = int'($urandom % 64000) * 4;
            en = 1;
            addr = ($urandom % 10 == 0) ? 18'($urandom_range(256000, 262143)) : 18'(base + int'($urandom % 8));
            data = 4'($urandom % 16);
            flush = ($urandom % 8 == 0);
            rcycle();
            flush = 0;
            repeat ($urandom_range(1, 2)) rcycle();
        end
        en = 0; ready = 1;
        repeat (40) cyc1();
        chk("rand count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("rand word%0d", i), got_q[i], exp_q[i]);
        chk("rand ovf", ovf, 0);
        chk("rand busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
